alu_issue_stage: RTL

- ID/EX issue stage that produces the EX-stage ALU operands and the 4-bit ALU control code; it is the driving end of the ALU's src1/src2/ctrl interface.
- Decodes opcode/funct and selects the immediate or register operand.
- Resolves RAW hazards by forwarding, or by a one-bubble load-use stall.
- Registers everything into the ID/EX pipeline register, with hold (stall) and bubble (flush) control.

---
 rtl/alu_issue_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the ALU control code, resolves operand hazards and registers the EX operands.
// Build option: define ALU_ISSUE_FWD_EN for EX/MEM forwarding; otherwise hazards are resolved by full interlock.
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [5:0]    id_opcode_i,
  input  logic [5:0]    id_funct_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic [RW-1:0] id_rd_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [DW-1:0] ex_result_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic [RW-1:0] mem_dst_i,
  input  logic          mem_regwrite_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic [DW-1:0] ex_src1_o,
  output logic [DW-1:0] ex_src2_o,
  output logic [3:0]    ex_ctrl_o,
  output logic [DW-1:0] ex_store_data_o,
  output logic [RW-1:0] ex_dst_o,
  output logic          ex_regwrite_o,
  output logic          ex_memread_o,
  output logic          ex_memwrite_o,
  output logic          ex_branch_o,
  output logic          ex_valid_o,
  output logic          illegal_o,
  output logic          stall_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [3:0]    dec_ctrl;
  logic          dec_use_imm;
  logic [RW-1:0] dec_dst;
  logic          dec_regwrite;
  logic          dec_memread;
  logic          dec_memwrite;
  logic          dec_branch;
  logic          dec_illegal;
  logic          dec_reads_rt;

  always_comb begin
    dec_ctrl     = 4'b0000;
    dec_use_imm  = 1'b0;
    dec_dst      = '0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    dec_illegal  = 1'b0;
    dec_reads_rt = 1'b0;
    case (id_opcode_i)
      OP_RTYPE: begin
        dec_reads_rt = 1'b1;
        dec_dst      = id_rd_i;
        dec_regwrite = 1'b1;
        case (id_funct_i)
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0011;
          6'b101010: dec_ctrl = 4'b0100;
          default: begin
            dec_illegal  = 1'b1;
            dec_dst      = '0;
            dec_regwrite = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_ctrl = 4'b0010; dec_use_imm = 1'b1; dec_dst = id_rt_i; dec_regwrite = 1'b1;
      end
      OP_SLTI: begin
        dec_ctrl = 4'b0100; dec_use_imm = 1'b1; dec_dst = id_rt_i; dec_regwrite = 1'b1;
      end
      OP_LW: begin
        dec_ctrl = 4'b0101; dec_use_imm = 1'b1; dec_dst = id_rt_i;
        dec_regwrite = 1'b1; dec_memread = 1'b1;
      end
      OP_SW: begin
        dec_ctrl = 4'b0110; dec_use_imm = 1'b1; dec_memwrite = 1'b1; dec_reads_rt = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl = 4'b0111; dec_branch = 1'b1; dec_reads_rt = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Operand 0 is rs, operand 1 is rt; both share the same hazard logic.
  logic [RW-1:0] opnd_idx  [2];
  logic [DW-1:0] opnd_rf   [2];
  logic [DW-1:0] opnd_val  [2];
  logic          load_dep  [2];
  logic          intlk_dep [2];

  assign opnd_idx[0] = id_rs_i;
  assign opnd_idx[1] = id_rt_i;
  assign opnd_rf[0]  = id_rs_data_i;
  assign opnd_rf[1]  = id_rt_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic idx_nz;
      assign idx_nz = (opnd_idx[gi] != '0);
      // A load in EX has no data yet, so it always costs one bubble.
      assign load_dep[gi] = ex_valid_o && ex_memread_o && (ex_dst_o != '0) &&
                            (ex_dst_o == opnd_idx[gi]);
`ifdef ALU_ISSUE_FWD_EN
      always_comb begin
        opnd_val[gi] = opnd_rf[gi];
        if (idx_nz && ex_valid_o && ex_regwrite_o && !ex_memread_o &&
            (ex_dst_o == opnd_idx[gi]))
          opnd_val[gi] = ex_result_i;
        else if (idx_nz && mem_regwrite_i && (mem_dst_i == opnd_idx[gi]))
          opnd_val[gi] = mem_result_i;
      end
      assign intlk_dep[gi] = 1'b0;
`else
      assign opnd_val[gi]  = opnd_rf[gi];
      assign intlk_dep[gi] = idx_nz &&
                             ((ex_valid_o && ex_regwrite_o && (ex_dst_o == opnd_idx[gi])) ||
                              (mem_regwrite_i && (mem_dst_i == opnd_idx[gi])));
`endif
    end
  endgenerate

`ifndef ALU_ISSUE_FWD_EN
  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_result_i, mem_result_i};
`endif

  assign stall_o = load_dep[0] || intlk_dep[0] ||
                   (dec_reads_rt && (load_dep[1] || intlk_dep[1]));

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || (!stall_i && stall_o)) begin
      ex_src1_o       <= '0;
      ex_src2_o       <= '0;
      ex_ctrl_o       <= 4'b0000;
      ex_store_data_o <= '0;
      ex_dst_o        <= '0;
      ex_regwrite_o   <= 1'b0;
      ex_memread_o    <= 1'b0;
      ex_memwrite_o   <= 1'b0;
      ex_branch_o     <= 1'b0;
      ex_valid_o      <= 1'b0;
      illegal_o       <= 1'b0;
    end else if (!stall_i) begin
      ex_src1_o       <= dec_illegal ? '0 : opnd_val[0];
      ex_src2_o       <= dec_illegal ? '0 : (dec_use_imm ? id_imm_i : opnd_val[1]);
      ex_ctrl_o       <= dec_ctrl;
      ex_store_data_o <= dec_illegal ? '0 : opnd_val[1];
      ex_dst_o        <= dec_dst;
      ex_regwrite_o   <= dec_regwrite;
      ex_memread_o    <= dec_memread;
      ex_memwrite_o   <= dec_memwrite;
      ex_branch_o     <= dec_branch;
      ex_valid_o      <= 1'b1;
      illegal_o       <= dec_illegal;
    end
  end

endmodule
